// File: rtl/rst_seq_pkg.sv
// Shared types and default timing constants for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK,
        ST_REL_MEM,
        ST_REL_CORE,
        ST_RUN,
        ST_SW_HOLD
    } state_t;

    localparam int DEF_LOCK_FILT = 8;
    localparam int DEF_STAGE_CYC = 16;
    localparam int DEF_WDOG_CYC  = 65536;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop negedge synchronizer for asynchronous level inputs, cleared by RST_n.
module sync2 (
    input  logic clk,
    input  logic RST_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // NOTE: flops use non-blocking assignments so both stages sample their old values on the same edge.
    always_ff @(negedge clk or negedge RST_n) begin
        if (!RST_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/rst_seq_ctrl.sv
// Staged reset release for memory, core and peripheral domains after PLL lock.
// Optional watchdog enabled by defining RST_WDOG_EN.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int LOCK_FILT = DEF_LOCK_FILT,
    parameter int STAGE_CYC = DEF_STAGE_CYC
`ifdef RST_WDOG_EN
    , parameter int WDOG_CYC = DEF_WDOG_CYC
`endif
) (
    input  logic clk,
    input  logic RST_n,
    input  logic pll_locked,
    input  logic sw_rst_req,
`ifdef RST_WDOG_EN
    input  logic wdog_kick,
`endif
    output logic rst_n_mem,
    output logic rst_n_core,
    output logic rst_n_periph,
    output logic rst_done,
    output logic wdog_fired
);

    localparam int                CNT_W     = $clog2(max2(LOCK_FILT, STAGE_CYC) + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  LOCK_TGT  = CNT_W'(LOCK_FILT);
    localparam logic [CNT_W-1:0]  STAGE_TGT = CNT_W'(STAGE_CYC);

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
    logic             r_rst_n_mem, r_rst_n_core, r_rst_n_periph, r_rst_done;
    logic             w_mem_nx, w_core_nx, w_periph_nx, w_done_nx;
    logic             w_lock_s, w_sw_s, r_sw_d, w_sw_rise;
    logic             w_wd_expire;

    sync2 u_sync_lock (.clk(clk), .RST_n(RST_n), .i_d(pll_locked), .o_q(w_lock_s));
    sync2 u_sync_sw   (.clk(clk), .RST_n(RST_n), .i_d(sw_rst_req), .o_q(w_sw_s));

    assign w_sw_rise = w_sw_s & ~r_sw_d;
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        // NOTE: every comb output gets a default first, so no path can infer a latch.
        w_state_nx  = r_state;
        w_cnt_nx    = r_cnt;
        w_mem_nx    = r_rst_n_mem;
        w_core_nx   = r_rst_n_core;
        w_periph_nx = r_rst_n_periph;
        w_done_nx   = r_rst_done;

        // Lock loss outranks software reset and watchdog expiry.
        if (r_state != ST_WAIT_LOCK && !w_lock_s) begin
            w_state_nx  = ST_WAIT_LOCK;
            w_cnt_nx    = '0;
            w_mem_nx    = 1'b0;
            w_core_nx   = 1'b0;
            w_periph_nx = 1'b0;
            w_done_nx   = 1'b0;
        end else begin
            case (r_state)
                ST_WAIT_LOCK: begin
                    w_mem_nx    = 1'b0;
                    w_core_nx   = 1'b0;
                    w_periph_nx = 1'b0;
                    w_done_nx   = 1'b0;
                    if (!w_lock_s) begin
                        w_cnt_nx = '0;
                    end else if (w_cnt_inc == LOCK_TGT) begin
                        w_cnt_nx   = '0;
                        w_mem_nx   = 1'b1;
                        w_state_nx = ST_REL_MEM;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                ST_REL_MEM: begin
                    if (w_cnt_inc == STAGE_TGT) begin
                        w_cnt_nx   = '0;
                        w_core_nx  = 1'b1;
                        w_state_nx = ST_REL_CORE;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                ST_REL_CORE: begin
                    if (w_cnt_inc == STAGE_TGT) begin
                        w_cnt_nx    = '0;
                        w_periph_nx = 1'b1;
                        w_done_nx   = 1'b1;
                        w_state_nx  = ST_RUN;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                ST_RUN: begin
                    if (w_sw_rise || w_wd_expire) begin
                        w_cnt_nx    = '0;
                        w_core_nx   = 1'b0;
                        w_periph_nx = 1'b0;
                        w_done_nx   = 1'b0;
                        w_state_nx  = ST_SW_HOLD;
                    end
                end
                ST_SW_HOLD: begin
                    // Memory stays released; core restarts on the normal REL_MEM timing.
                    if (w_cnt_inc == STAGE_TGT) begin
                        w_cnt_nx   = '0;
                        w_state_nx = ST_REL_MEM;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nx  = ST_WAIT_LOCK;
                    w_cnt_nx    = '0;
                    w_mem_nx    = 1'b0;
                    w_core_nx   = 1'b0;
                    w_periph_nx = 1'b0;
                    w_done_nx   = 1'b0;
                end
            endcase
        end
    end

    // Outputs are registered so RST_n can clear them asynchronously without glitches.
    always_ff @(negedge clk or negedge RST_n) begin
        if (!RST_n) begin
            r_state        <= ST_WAIT_LOCK;
            r_cnt          <= '0;
            r_sw_d         <= 1'b0;
            r_rst_n_mem    <= 1'b0;
            r_rst_n_core   <= 1'b0;
            r_rst_n_periph <= 1'b0;
            r_rst_done     <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_cnt          <= w_cnt_nx;
            r_sw_d         <= w_sw_s;
            r_rst_n_mem    <= w_mem_nx;
            r_rst_n_core   <= w_core_nx;
            r_rst_n_periph <= w_periph_nx;
            r_rst_done     <= w_done_nx;
        end
    end

`ifdef RST_WDOG_EN
    localparam int               WD_W   = $clog2(WDOG_CYC + 1);
    localparam logic [WD_W-1:0]  WD_TGT = WD_W'(WDOG_CYC);

    logic [WD_W-1:0] r_wd_cnt, w_wd_inc;
    logic            r_wdog_fired;

    assign w_wd_inc    = (r_wd_cnt == {WD_W{1'b1}}) ? r_wd_cnt : r_wd_cnt + 1'b1;
    assign w_wd_expire = (r_state == ST_RUN) && !wdog_kick && (w_wd_inc == WD_TGT);

    // The flag is sticky across lock loss and software reset; only RST_n clears it.
    always_ff @(negedge clk or negedge RST_n) begin
        if (!RST_n) begin
            r_wd_cnt     <= '0;
            r_wdog_fired <= 1'b0;
        end else begin
            if (r_state != ST_RUN || w_state_nx != ST_RUN || wdog_kick)
                r_wd_cnt <= '0;
            else
                r_wd_cnt <= w_wd_inc;
            if (r_state == ST_RUN && w_state_nx == ST_SW_HOLD && w_wd_expire)
                r_wdog_fired <= 1'b1;
        end
    end

    assign wdog_fired = r_wdog_fired;
`else
    assign w_wd_expire = 1'b0;
    assign wdog_fired  = 1'b0;
`endif

    assign rst_n_mem    = r_rst_n_mem;
    assign rst_n_core   = r_rst_n_core;
    assign rst_n_periph = r_rst_n_periph;
    assign rst_done     = r_rst_done;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with LOCK_FILT=3, STAGE_CYC=4, WDOG_CYC=20.
module tb_rst_seq_ctrl;

    logic clk;
    logic RST_n;
    logic pll_locked;
    logic sw_rst_req;
`ifdef RST_WDOG_EN
    logic wdog_kick;
    logic kick_en;
`endif
    logic rst_n_mem;
    logic rst_n_core;
    logic rst_n_periph;
    logic rst_done;
    logic wdog_fired;

    int n_total = 0;
    int n_bad   = 0;

    rst_seq_ctrl #(
        .LOCK_FILT(3),
        .STAGE_CYC(4)
`ifdef RST_WDOG_EN
        , .WDOG_CYC(20)
`endif
    ) dut (
        .clk         (clk),
        .RST_n       (RST_n),
        .pll_locked  (pll_locked),
        .sw_rst_req  (sw_rst_req),
`ifdef RST_WDOG_EN
        .wdog_kick   (wdog_kick),
`endif
        .rst_n_mem   (rst_n_mem),
        .rst_n_core  (rst_n_core),
        .rst_n_periph(rst_n_periph),
        .rst_done    (rst_done),
        .wdog_fired  (wdog_fired)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

`ifdef RST_WDOG_EN
    // Kick every fourth cycle whenever enabled, so normal RUN periods never time out.
    initial begin
        int k;
        k = 0;
        wdog_kick = 1'b0;
        forever begin
            @(posedge clk);
            wdog_kick = kick_en && (k == 0);
            k = (k + 1) % 4;
        end
    end
`endif

    task automatic check(input string tag, input logic obs, input logic exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", tag, obs, exp);
        end
    endtask

    // Advance n falling edges, then sample just after the last one.
    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic exp);
        check({tag, ":mem"},    rst_n_mem,    exp);
        check({tag, ":core"},   rst_n_core,   exp);
        check({tag, ":periph"}, rst_n_periph, exp);
        check({tag, ":done"},   rst_done,     exp);
    endtask

    // Called just after the posedge where RST_n or pll_locked rose; expects edges 5/9/13.
    task automatic powerup(input string tag);
        wait_neg(4);
        check({tag, ":mem@4"},    rst_n_mem,    1'b0);
        wait_neg(1);
        check({tag, ":mem@5"},    rst_n_mem,    1'b1);
        check({tag, ":core@5"},   rst_n_core,   1'b0);
        wait_neg(3);
        check({tag, ":core@8"},   rst_n_core,   1'b0);
        wait_neg(1);
        check({tag, ":core@9"},   rst_n_core,   1'b1);
        check({tag, ":periph@9"}, rst_n_periph, 1'b0);
        wait_neg(3);
        check({tag, ":periph@12"}, rst_n_periph, 1'b0);
        check({tag, ":done@12"},   rst_done,     1'b0);
        wait_neg(1);
        check_all({tag, "@13"}, 1'b1);
    endtask

    initial begin
        RST_n      = 1'b0;
        pll_locked = 1'b1;
        sw_rst_req = 1'b0;
`ifdef RST_WDOG_EN
        kick_en    = 1'b1;
`endif
        #1;
        check_all("rst0", 1'b0);
        wait_neg(3);
        check_all("rst_hold", 1'b0);

        // Power-up with lock held high.
        @(posedge clk);
        RST_n = 1'b1;
        powerup("pwr");

        // Software reset pulse in RUN.
        @(posedge clk);
        sw_rst_req = 1'b1;
        wait_neg(2);
        check("sw:core_pre", rst_n_core, 1'b1);
        @(posedge clk);
        sw_rst_req = 1'b0;
        wait_neg(1);
        check("sw:mem_kept", rst_n_mem,    1'b1);
        check("sw:core_lo",  rst_n_core,   1'b0);
        check("sw:per_lo",   rst_n_periph, 1'b0);
        check("sw:done_lo",  rst_done,     1'b0);
        wait_neg(7);
        check("sw:core@7",   rst_n_core,   1'b0);
        check("sw:mem@7",    rst_n_mem,    1'b1);
        wait_neg(1);
        check("sw:core@8",   rst_n_core,   1'b1);
        check("sw:per@8",    rst_n_periph, 1'b0);
        wait_neg(3);
        check("sw:per@11",   rst_n_periph, 1'b0);
        wait_neg(1);
        check("sw:per@12",   rst_n_periph, 1'b1);
        check("sw:done@12",  rst_done,     1'b1);

        // Lock loss in RUN, then full sequence on relock.
        @(posedge clk);
        pll_locked = 1'b0;
        wait_neg(2);
        check("lol:mem_pre",  rst_n_mem, 1'b1);
        check("lol:done_pre", rst_done,  1'b1);
        wait_neg(1);
        check_all("lol", 1'b0);
        wait_neg(2);
        @(posedge clk);
        pll_locked = 1'b1;
        powerup("relock");

        // Sw request outside RUN is ignored: fresh reset, pulse during WAIT_LOCK/REL_MEM.
        @(posedge clk);
        RST_n = 1'b0;
        #1;
        check_all("rst1", 1'b0);
        wait_neg(2);
        @(posedge clk);
        RST_n = 1'b1;
        sw_rst_req = 1'b1;
        powerup("sw_ign");
        sw_rst_req = 1'b0;
        wait_neg(4);
        check("sw_ign:core_run", rst_n_core, 1'b1);

        // Lock glitch while the filter count is 2.
        @(posedge clk);
        RST_n = 1'b0;
        wait_neg(2);
        @(posedge clk);
        RST_n = 1'b1;
        wait_neg(2);
        @(posedge clk);
        pll_locked = 1'b0;
        wait_neg(2);
        @(posedge clk);
        pll_locked = 1'b1;
        wait_neg(1);
        check("gl:mem@5", rst_n_mem, 1'b0);
        wait_neg(3);
        check("gl:mem@8", rst_n_mem, 1'b0);
        wait_neg(1);
        check("gl:mem@9", rst_n_mem, 1'b1);
        wait_neg(4);
        check("gl:core@13", rst_n_core, 1'b1);

        // RST_n during REL_CORE clears outputs before any clock edge.
        wait_neg(1);
        @(posedge clk);
        RST_n = 1'b0;
        #1;
        check_all("async", 1'b0);
        #5;
        check("async:core_hold", rst_n_core, 1'b0);
        wait_neg(1);

`ifdef RST_WDOG_EN
        kick_en = 1'b0;
        @(posedge clk);
        RST_n = 1'b1;
        powerup("wd");
        wait_neg(19);
        check("wd:fired@19", wdog_fired, 1'b0);
        check("wd:core@19",  rst_n_core, 1'b1);
        wait_neg(1);
        check("wd:fired@20", wdog_fired, 1'b1);
        check("wd:core@20",  rst_n_core, 1'b0);
        check("wd:mem@20",   rst_n_mem,  1'b1);
        kick_en = 1'b1;
        wait_neg(8);
        check("wd:core_rel", rst_n_core, 1'b1);
        wait_neg(4);
        check("wd:done_rel", rst_done,   1'b1);
        check("wd:sticky",   wdog_fired, 1'b1);
        @(posedge clk);
        pll_locked = 1'b0;
        wait_neg(3);
        check("wd:lol_mem",    rst_n_mem,  1'b0);
        check("wd:lol_sticky", wdog_fired, 1'b1);
        @(posedge clk);
        pll_locked = 1'b1;
        RST_n = 1'b0;
        #1;
        check("wd:cleared", wdog_fired, 1'b0);
`else
        check("wd:tied0", wdog_fired, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
